// File: rtl/code_uart_tx_if.sv
// code_uart_tx_if: read-side handshake between the key code FIFO and its UART reader
interface code_uart_tx_if;
  logic       empty;
  logic [3:0] code;
  logic       rd_enable;
  modport master (output rd_enable, input empty, code);
  modport slave  (input rd_enable, output empty, code);
endinterface

// File: rtl/code_uart_tx.sv
// code_uart_tx: pops 4-bit key codes from a FIFO and sends each as an ASCII hex char in an 8N1 UART frame
module code_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  code_uart_tx_if.master   fifo,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count
);
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;
  state_t           state, state_n;
  logic             rd_n, tx_n, last;
  logic [15:0]      baud, baud_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       chr, chr_n, ascii;
  logic [CNT_W-1:0] cnt_n;
  assign last  = baud == 16'(CLKS_PER_BIT - 1);
  assign ascii = fifo.code < 4'd10 ? 8'h30 + {4'h0, fifo.code} : 8'h37 + {4'h0, fifo.code};
  assign busy  = state != IDLE;
  always_ff @(posedge clock)
    if (reset) begin
      state          <= IDLE;
      fifo.rd_enable <= 1'b0;
      tx             <= 1'b1;
      baud           <= '0;
      bit_idx        <= '0;
      chr            <= '0;
      sent_count     <= '0;
    end else begin
      state          <= state_n;
      fifo.rd_enable <= rd_n;
      tx             <= tx_n;
      baud           <= baud_n;
      bit_idx        <= bit_n;
      chr            <= chr_n;
      sent_count     <= cnt_n;
    end
  // tx_n is the next line level; tx itself is only ever a flop output
  always_comb begin
    state_n = state;
    rd_n    = 1'b0;
    tx_n    = tx;
    baud_n  = baud;
    bit_n   = bit_idx;
    chr_n   = chr;
    cnt_n   = sent_count;
    case (state)
      IDLE: begin
        tx_n    = 1'b1;
        rd_n    = !fifo.empty;
        state_n = fifo.empty ? IDLE : POP;
      end
      POP: state_n = LATCH;
      LATCH: begin
        chr_n   = ascii;
        tx_n    = 1'b0;
        baud_n  = '0;
        state_n = START;
      end
      START: begin
        baud_n  = last ? 16'd0 : baud + 16'd1;
        tx_n    = last ? chr[0] : tx;
        bit_n   = last ? 3'd0 : bit_idx;
        state_n = last ? DATA : START;
      end
      DATA: begin
        baud_n  = last ? 16'd0 : baud + 16'd1;
        bit_n   = last ? bit_idx + 3'd1 : bit_idx;
        tx_n    = !last ? tx : bit_idx == 3'd7 ? 1'b1 : chr[bit_idx + 3'd1];
        state_n = last && bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: begin
        baud_n  = last ? 16'd0 : baud + 16'd1;
        cnt_n   = last ? sent_count + 1'b1 : sent_count;
        state_n = last ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_code_uart_tx.sv
// tb_code_uart_tx: random key codes through a FIFO model, decoded off tx by a UART receiver model
module tb_code_uart_tx;
  localparam int C = 4;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx, busy;
  logic [7:0] sent_count;
  logic       glitch = 1'b0, zap = 1'b0;
  logic [3:0] f_code = 4'h0;
  logic [3:0] codes[$];
  int         rp = 0, n_codes = 0;
  int         cyc = 0, rst_cnt = 0, fall_n = 0, fall_cyc = 0, push_cyc = 0;
  int         rd_q[$];
  int         rd_consec = 0, bad_idle = 0;
  logic       prev_rd = 1'b0;
  logic [7:0] rx_q[$], exp_q[$];
  int         len_q[$];
  int         n_chk = 0, n_pass = 0;

  code_uart_tx_if bus ();
  code_uart_tx #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .fifo(bus.master),
    .tx(tx), .busy(busy), .sent_count(sent_count)
  );

  always #5 clock = ~clock;

  // FIFO model: a queue with a read pointer; data appears the cycle after the pop edge
  assign bus.empty = (rp >= n_codes) & ~glitch;
  assign bus.code  = zap ? 4'h0 : f_code;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) rst_cnt <= rst_cnt + 1;
    if (bus.rd_enable && rp < n_codes) begin
      f_code <= codes[rp];
      rp     <= rp + 1;
    end
  end

  always @(negedge clock) begin
    if (bus.rd_enable) begin
      rd_q.push_back(cyc);
      if (prev_rd) rd_consec <= rd_consec + 1;
    end
    prev_rd <= bus.rd_enable;
    if (!reset && !busy && !tx) bad_idle <= bad_idle + 1;
  end

  // UART receiver: samples mid-bit, drops frames that a reset cut short
  initial begin : mon
    logic       ptx, ok;
    logic [7:0] b;
    int         r0, len;
    ptx = 1'b1;
    forever begin
      @(negedge clock);
      if (ptx && !tx) begin
        r0 = rst_cnt;
        fall_cyc = cyc;
        fall_n++;
        repeat (C / 2) @(negedge clock);
        ok = !tx;
        for (int k = 0; k < 8; k++) begin
          repeat (C) @(negedge clock);
          b[k] = tx;
        end
        repeat (C) @(negedge clock);
        ok = ok & tx;
        len = C / 2 + 9 * C;
        while (busy && len < 20 * C) begin
          @(negedge clock);
          len++;
        end
        if (rst_cnt == r0) begin
          rx_q.push_back(b);
          len_q.push_back(ok ? len : 0);
        end
      end
      ptx = tx;
    end
  end

  function automatic logic [7:0] hex_char(input logic [3:0] c);
    logic [7:0] d, a;
    d = "0";
    a = "A";
    return (c < 4'd10) ? d + 8'(c) : a + 8'(c) - 8'd10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push_code(input logic [3:0] c);
    codes.push_back(c);
    n_codes = codes.size();
    exp_q.push_back(hex_char(c));
    push_cyc = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_fall(input int f0);
    int t;
    t = 0;
    while (fall_n == f0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("start_bit_seen", 32'(fall_n != f0), 1);
  endtask

  task automatic expect_frames(input int n);
    int t, m;
    t = 0;
    while (rx_q.size() < n && t < n * 60 + 60) begin
      @(negedge clock);
      t++;
    end
    chk("frame_count", rx_q.size(), n);
    m = rx_q.size() < exp_q.size() ? rx_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk("byte", rx_q.pop_front(), exp_q.pop_front());
      chk("frame_len", len_q.pop_front(), 10 * C);
    end
  endtask

  initial begin : main
    int f0, r0;
    glitch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_rd", bus.rd_enable, 0);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", sent_count, 0);
    end
    @(negedge clock);
    glitch = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_no_pop", rp, 0);

    f0 = fall_n;
    r0 = rd_q.size();
    push_code(4'h7);
    wait_fall(f0);
    chk("start_delay", fall_cyc - push_cyc, 3);
    expect_frames(1);
    chk("single_pops", rd_q.size() - r0, 1);
    chk("single_cnt", sent_count, 1);

    do_reset();
    r0 = rd_q.size();
    push_code(4'hA);
    push_code(4'hF);
    expect_frames(2);
    chk("pair_pops", rd_q.size() - r0, 2);
    if (rd_q.size() - r0 == 2) chk("pop_gap", rd_q[r0+1] - rd_q[r0], 10 * C + 3);
    chk("pair_cnt", sent_count, 2);

    f0 = fall_n;
    push_code(4'h3);
    wait_fall(f0);
    repeat (4 * C + 1) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", sent_count, 0);
    reset = 1'b0;
    exp_q.delete();
    r0 = rd_q.size();
    repeat (10 * C) @(negedge clock);
    chk("abort_no_pop", rd_q.size() - r0, 0);
    chk("abort_no_frame", rx_q.size(), 0);
    push_code(4'h9);
    expect_frames(1);
    chk("after_abort_cnt", sent_count, 1);

    f0 = fall_n;
    r0 = rd_q.size();
    push_code(4'h5);
    wait_fall(f0);
    repeat (3 * C) @(negedge clock);
    zap = 1'b1;
    for (int i = 0; i < 12; i++) begin
      glitch = ~glitch;
      @(negedge clock);
    end
    glitch = 1'b0;
    expect_frames(1);
    zap = 1'b0;
    chk("glitch_pops", rd_q.size() - r0, 1);
    chk("glitch_cnt", sent_count, 2);

    do_reset();
    for (int i = 0; i < 256; i++) push_code(4'($urandom_range(0, 15)));
    expect_frames(256);
    chk("wrap_cnt", sent_count, 0);
    chk("idle_high", bad_idle, 0);
    chk("rd_single_cycle", rd_consec, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
